// File: rtl/md_sched.sv
// Multiply/divide scheduler: serialises slot 0 then slot 1 mul/div ops onto one
// multiplier and one 32-step radix-2 restoring divider. Optional: MD_MUL_PIPE_EN (2-cycle multiply).
module md_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [1:0]  op0_i,
  input  logic [1:0]  op1_i,
  input  logic [31:0] a0_i,
  input  logic [31:0] b0_i,
  input  logic [31:0] a1_i,
  input  logic [31:0] b1_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {S_IDLE, S_EXE, S_WB} state_e;

  state_e             state_q, state_d;
  logic               pend0_q, pend0_d, pend1_q, pend1_d;
  logic               sel_q, sel_d;
  logic [1:0]         op0_q, op0_d, op1_q, op1_d;
  logic [W-1:0]       a0_q, a0_d, b0_q, b0_d, a1_q, a1_d, b1_q, b1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       rem_q, rem_d, quo_q, quo_d;
  logic [W-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic               we_q, we_d;
`ifdef MD_MUL_PIPE_EN
  logic [2*W-1:0]     ma_q, ma_d, mb_q, mb_d;
`endif

  // Current-slot operand selection and sign/magnitude preparation
  logic [1:0]   cur_op;
  logic [W-1:0] cur_a, cur_b, a_mag, b_mag;
  logic         a_neg, b_neg, is_div;
  logic [2*W-1:0] mul_a, mul_b, prod;

  assign cur_op = sel_q ? op1_q : op0_q;
  assign cur_a  = sel_q ? a1_q  : a0_q;
  assign cur_b  = sel_q ? b1_q  : b0_q;
  assign is_div = cur_op[1];
  assign a_neg  = ~cur_op[0] & cur_a[W-1];
  assign b_neg  = ~cur_op[0] & cur_b[W-1];
  assign a_mag  = a_neg ? (~cur_a + W'(1)) : cur_a;
  assign b_mag  = b_neg ? (~cur_b + W'(1)) : cur_b;
  assign mul_a  = {{W{a_neg}}, cur_a};
  assign mul_b  = {{W{b_neg}}, cur_b};
`ifdef MD_MUL_PIPE_EN
  assign prod   = ma_q * mb_q;
`else
  assign prod   = mul_a * mul_b;
`endif

  // One restoring divide step; step 0 seeds from the operand magnitudes
  logic [W-1:0] rem_in, quo_in, rem_nx, quo_nx, q_fix, r_fix;
  logic [W:0]   shifted;
  logic         ge;

  assign rem_in  = (cnt_q == '0) ? '0    : rem_q;
  assign quo_in  = (cnt_q == '0) ? a_mag : quo_q;
  assign shifted = {rem_in, quo_in[W-1]};
  assign ge      = shifted >= {1'b0, b_mag};
  assign rem_nx  = ge ? W'(shifted - {1'b0, b_mag}) : shifted[W-1:0];
  assign quo_nx  = {quo_in[W-2:0], ge};
  assign q_fix   = (a_neg ^ b_neg) ? (~quo_nx + W'(1)) : quo_nx;
  assign r_fix   = a_neg ? (~rem_nx + W'(1)) : rem_nx;

  logic other_pend;
  assign other_pend = ~sel_q & pend1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      sel_q   <= 1'b0;
      op0_q   <= '0;
      op1_q   <= '0;
      a0_q    <= '0;
      b0_q    <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
`ifdef MD_MUL_PIPE_EN
      ma_q    <= '0;
      mb_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      sel_q   <= sel_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
`ifdef MD_MUL_PIPE_EN
      ma_q    <= ma_d;
      mb_q    <= mb_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pend0_d = pend0_q;
    pend1_d = pend1_q;
    sel_d   = sel_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    a0_d    = a0_q;
    b0_d    = b0_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = '0;
    lo_d    = '0;
    we_d    = 1'b0;
`ifdef MD_MUL_PIPE_EN
    ma_d    = ma_q;
    mb_d    = mb_q;
`endif
    if (flush_i) begin
      state_d = S_IDLE;
      pend0_d = 1'b0;
      pend1_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req0_i | req1_i) begin
            op0_d   = op0_i;
            op1_d   = op1_i;
            a0_d    = a0_i;
            b0_d    = b0_i;
            a1_d    = a1_i;
            b1_d    = b1_i;
            pend0_d = req0_i;
            pend1_d = req1_i;
            sel_d   = ~req0_i;
            cnt_d   = '0;
            state_d = S_EXE;
          end
        end
        S_EXE: begin
          if (is_div) begin
            if (cur_b == '0) begin
              hi_d    = cur_a;
              lo_d    = '1;
              we_d    = 1'b1;
              state_d = S_WB;
            end else begin
              rem_d = rem_nx;
              quo_d = quo_nx;
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_q == '1) begin
                hi_d    = r_fix;
                lo_d    = q_fix;
                we_d    = 1'b1;
                state_d = S_WB;
              end
            end
          end else begin
`ifdef MD_MUL_PIPE_EN
            if (cnt_q == '0) begin
              ma_d  = mul_a;
              mb_d  = mul_b;
              cnt_d = CNT_W'(1);
            end else begin
              hi_d    = prod[2*W-1:W];
              lo_d    = prod[W-1:0];
              we_d    = 1'b1;
              state_d = S_WB;
            end
`else
            hi_d    = prod[2*W-1:W];
            lo_d    = prod[W-1:0];
            we_d    = 1'b1;
            state_d = S_WB;
`endif
          end
        end
        S_WB: begin
          if (sel_q) pend1_d = 1'b0;
          else       pend0_d = 1'b0;
          if (other_pend) begin
            sel_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_EXE;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Final WB releases the pipeline so the held request is not taken twice
  logic final_wb;
  assign final_wb  = (state_q == S_WB) & ~other_pend;
  assign busy_o    = (state_q != S_IDLE);
  assign stall_o   = (req0_i | req1_i | busy_o) & ~final_wb & ~flush_i;
  assign hilo_we_o = we_q & ~flush_i;
  assign hi_o      = hi_q & {W{~flush_i}};
  assign lo_o      = lo_q & {W{~flush_i}};

endmodule

// File: tb/tb_md_sched.sv
// Randomized self-checking bench for md_sched against an arithmetic reference model.
module tb_md_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_i, req1_i, flush_i;
  logic [1:0]  op0_i, op1_i;
  logic [31:0] a0_i, b0_i, a1_i, b1_i;
  logic        stall_o, busy_o, hilo_we_o;
  logic [31:0] hi_o, lo_o;

  int n_chk = 0;
  int n_err = 0;

  md_sched dut (
    .clk(clk), .rst(rst),
    .req0_i(req0_i), .req1_i(req1_i),
    .op0_i(op0_i), .op1_i(op1_i),
    .a0_i(a0_i), .b0_i(b0_i), .a1_i(a1_i), .b1_i(b1_i),
    .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .hilo_we_o(hilo_we_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference results from plain integer arithmetic
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op[1]) begin
      if (b == 0) return {a, 32'hFFFF_FFFF};
      if (op[0] == 1'b0) begin
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      return {a % b, a / b};
    end
    if (op[0] == 1'b0) begin
      p = sa * sb;
      return 64'(p);
    end
    up = {32'b0, a} * {32'b0, b};
    return up;
  endfunction

  function automatic int ref_len(input logic [1:0] op, input logic [31:0] b);
    if (op[1]) return (b == 0) ? 1 : 32;
`ifdef MD_MUL_PIPE_EN
    return 2;
`else
    return 1;
`endif
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] sp [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
    return $urandom;
  endfunction

  task automatic idle_inputs();
    req0_i = 0; req1_i = 0; flush_i = 0;
    op0_i = 0; op1_i = 0; a0_i = 0; b0_i = 0; a1_i = 0; b1_i = 0;
  endtask

  // Issue a bundle in the current cycle and check every cycle through the final WB
  task automatic run(input logic r0, input logic [1:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                     input logic r1, input logic [1:0] o1, input logic [31:0] x1, input logic [31:0] y1);
    logic [63:0] res0, res1, expv;
    int e0, e1, wba, wbb, fin;
    logic ew;
    res0 = ref_res(o0, x0, y0);
    res1 = ref_res(o1, x1, y1);
    e0 = ref_len(o0, y0);
    e1 = ref_len(o1, y1);
    wbb = -1;
    if (r0 && r1) begin wba = e0 + 1; wbb = e0 + e1 + 2; fin = wbb; end
    else if (r0)  begin wba = e0 + 1; fin = wba; end
    else          begin wba = e1 + 1; fin = wba; res0 = res1; end
    req0_i = r0; req1_i = r1; op0_i = o0; op1_i = o1;
    a0_i = x0; b0_i = y0; a1_i = x1; b1_i = y1;
    #1;
    chk("stall_accept", 64'(stall_o), 64'(1));
    for (int k = 1; k <= fin + 1; k++) begin
      @(negedge clk);
      if (k == fin + 1) idle_inputs();
      #1;
      ew = (k == wba) || (k == wbb);
      expv = (k == wba) ? res0 : (k == wbb) ? res1 : 64'h0;
      chk("hilo_we", 64'(hilo_we_o), 64'(ew));
      chk("hi_lo", {hi_o, lo_o}, expv);
      chk("stall", 64'(stall_o), 64'(k < fin));
      chk("busy", 64'(busy_o), 64'(k <= fin));
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_state", {29'b0, stall_o, busy_o, hilo_we_o, hi_o}, 64'h0);
    chk("rst_lo", 64'(lo_o), 64'h0);
    @(negedge clk);

    run(1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2'b00, 0, 0);
    run(1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2'b00, 0, 0);
    run(1, 2'b10, 32'd7, 32'hFFFF_FFFE, 0, 2'b00, 0, 0);
    run(1, 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 2'b00, 0, 0);
    run(1, 2'b11, 32'd100, 32'd7, 0, 2'b00, 0, 0);
    run(1, 2'b11, 32'd10, 32'd3, 1, 2'b01, 32'd5, 32'd6);
    run(1, 2'b10, 32'h1234, 32'd0, 0, 2'b00, 0, 0);
    run(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2'b00, 0, 0);
    run(0, 2'b00, 0, 0, 1, 2'b11, 32'hFFFF_FFFF, 32'd16);

    // Flush mid-divide
    req0_i = 1; op0_i = 2'b10; a0_i = 32'd1000; b0_i = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) begin idle_inputs(); flush_i = 1; end
      #1;
      chk("flush_stall", 64'(stall_o), 64'(k < 10));
      chk("flush_we", 64'(hilo_we_o), 64'h0);
    end
    for (int k = 11; k <= 40; k++) begin
      @(negedge clk);
      flush_i = 0;
      #1;
      chk("flush_idle", {62'b0, busy_o, hilo_we_o}, 64'h0);
    end

    // Synchronous reset mid-divide
    req0_i = 1; op0_i = 2'b11; a0_i = 32'd5000; b0_i = 32'd7;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) begin idle_inputs(); rst = 1; end
      if (k == 6) rst = 0;
      #1;
      if (k == 6) begin
        chk("rst_mid_ctl", {61'b0, stall_o, busy_o, hilo_we_o}, 64'h0);
        chk("rst_mid_hilo", {hi_o, lo_o}, 64'h0);
      end
    end
    repeat (6) @(negedge clk);
    #1;
    run(1, 2'b01, 32'd12345, 32'd678, 0, 2'b00, 0, 0);

    for (int t = 0; t < 40; t++) begin
      logic r0, r1;
      r0 = 1'($urandom_range(1));
      r1 = r0 ? 1'($urandom_range(1)) : 1'b1;
      run(r0, 2'($urandom), pick(), pick(), r1, 2'($urandom), pick(), pick());
      if ($urandom_range(1) == 1) begin
        @(negedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
